// File: rtl/ascon_serial_io.sv
// Serial load/unload wrapper around a parallel Ascon AEAD core: W-bit beats in,
// parallel operands to the core, W-bit beats of result and tag back out.
module ascon_serial_io #(
  parameter int unsigned K = 128,
  parameter int unsigned L = 128,
  parameter int unsigned Y = 128,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] key_in,
  input  logic [W-1:0] nonce_in,
  input  logic [W-1:0] ad_in,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] tag_in,
  input  logic         mode,
  input  logic         start,
  output logic         core_start,
  output logic         core_mode,
  output logic [K-1:0] core_key,
  output logic [127:0] core_nonce,
  output logic [L-1:0] core_ad,
  output logic [Y-1:0] core_data,
  input  logic         core_done,
  input  logic [Y-1:0] core_result,
  input  logic [127:0] core_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [W-1:0] tag_out,
  output logic         auth_fail,
  output logic [15:0]  lat_cnt
);

  localparam int unsigned M1 = (K > L) ? K : L;
  localparam int unsigned M2 = (Y > 128) ? Y : 128;
  localparam int unsigned M  = (M1 > M2) ? M1 : M2;
  localparam int unsigned NB = M / W;   // load beats
  localparam int unsigned NO = M2 / W;  // unload beats
  localparam int unsigned CW = $clog2(NB + 1);

  if ((K % W) != 0 || (L % W) != 0 || (Y % W) != 0 || (128 % W) != 0) begin : g_bad_w
    $error("ascon_serial_io: K, L, Y and 128 must be multiples of W");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RUN, S_UNLOAD} state_t;

  state_t         state, next;
  logic [CW-1:0]  cnt;
  logic [127:0]   tag_r;
  logic [Y-1:0]   res_r;
  logic [127:0]   tagc_r;
  logic           acc;
  logic           fail;

  assign in_ready  = rst && (state == S_IDLE || state == S_LOAD);
  assign acc       = in_valid && in_ready;
  assign out_valid = (state == S_UNLOAD);
  assign data_out  = res_r[Y-1 -: W];
  assign tag_out   = tagc_r[127 -: W];
  assign fail      = core_mode && (core_tag != tag_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (acc) next = (NB == 1) ? S_ARMED : S_LOAD;
      S_LOAD:   if (acc && cnt == CW'(NB - 1)) next = S_ARMED;
      S_ARMED:  if (start) next = S_RUN;
      S_RUN:    if (core_done) next = S_UNLOAD;
      S_UNLOAD: if (out_ready && cnt == CW'(NO - 1)) next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  // Lanes are shift registers fed MSB first; a lane stops shifting once it
  // has taken len/W beats, so later slices are dropped and stale data is
  // fully displaced by the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      core_key   <= '0;
      core_nonce <= '0;
      core_ad    <= '0;
      core_data  <= '0;
      tag_r      <= '0;
      res_r      <= '0;
      tagc_r     <= '0;
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      auth_fail  <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      core_start <= 1'b0;
      if (acc) begin
        if (cnt < CW'(K / W))   core_key   <= (core_key << W)   | K'(key_in);
        if (cnt < CW'(128 / W)) core_nonce <= (core_nonce << W) | 128'(nonce_in);
        if (cnt < CW'(L / W))   core_ad    <= (core_ad << W)    | L'(ad_in);
        if (cnt < CW'(Y / W))   core_data  <= (core_data << W)  | Y'(data_in);
        if (cnt < CW'(128 / W)) tag_r      <= (tag_r << W)      | 128'(tag_in);
        cnt <= (next == S_ARMED) ? '0 : cnt + CW'(1);
      end
      case (state)
        S_ARMED: if (start) begin
          core_mode  <= mode;
          core_start <= 1'b1;
          lat_cnt    <= '0;
          auth_fail  <= 1'b0;
        end
        S_RUN: if (core_done) begin
          res_r     <= fail ? '0 : core_result;
          tagc_r    <= core_tag;
          auth_fail <= fail;
        end else if (lat_cnt != '1) begin
          lat_cnt <= lat_cnt + 16'd1;
        end
        S_UNLOAD: if (out_ready) begin
          res_r  <= res_r << W;
          tagc_r <= tagc_r << W;
          cnt    <= (cnt == CW'(NO - 1)) ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serial_io.sv
// Directed bench for ascon_serial_io: stubbed core, default and narrow-beat
// instances, encrypt/decrypt, throttling, latency saturation and reset abort.
module tb_ascon_serial_io;

  localparam logic [127:0] KEY  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NON2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] AD2  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] DAT2 = 128'hDEADBEEF0123456789ABCDEFFEEDFACE;
  localparam logic [127:0] RES  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] TAG  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [63:0]  AD_S = 64'h1122334455667788;
  localparam logic [31:0]  DAT_S = 32'h89ABCDEF;
  localparam logic [31:0]  RES_S = 32'hCAFEF00D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic         in_valid, in_ready, mode, start, core_start, core_mode, core_done;
  logic [7:0]   key_in, nonce_in, ad_in, data_in, tag_in, data_out, tag_out;
  logic [127:0] core_key, core_nonce, core_ad, core_data;
  logic         out_valid, out_ready, auth_fail;
  logic [15:0]  lat_cnt;

  ascon_serial_io u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .data_in(data_in), .tag_in(tag_in),
    .mode(mode), .start(start), .core_start(core_start), .core_mode(core_mode),
    .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_data(core_data),
    .core_done(core_done), .core_result(RES), .core_tag(TAG),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .tag_out(tag_out),
    .auth_fail(auth_fail), .lat_cnt(lat_cnt)
  );

  // narrow instance: K=128, L=64, Y=32, W=4
  logic         s_in_valid, s_in_ready, s_start, s_core_start, s_core_mode, s_out_valid, s_out_ready;
  logic [3:0]   s_key, s_nonce, s_ad, s_data, s_tag, s_data_out, s_tag_out;
  logic [127:0] s_core_key, s_core_nonce;
  logic [63:0]  s_core_ad;
  logic [31:0]  s_core_data;
  logic         s_done = 1'b0;
  logic         s_auth_fail;
  logic [15:0]  s_lat_cnt;

  ascon_serial_io #(.K(128), .L(64), .Y(32), .W(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .key_in(s_key), .nonce_in(s_nonce), .ad_in(s_ad), .data_in(s_data), .tag_in(s_tag),
    .mode(1'b0), .start(s_start), .core_start(s_core_start), .core_mode(s_core_mode),
    .core_key(s_core_key), .core_nonce(s_core_nonce), .core_ad(s_core_ad), .core_data(s_core_data),
    .core_done(s_done), .core_result(RES_S), .core_tag(TAG),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .data_out(s_data_out), .tag_out(s_tag_out),
    .auth_fail(s_auth_fail), .lat_cnt(s_lat_cnt)
  );

  // core stubs: default core finishes in RUN cycle dly, narrow core one cycle after start
  int unsigned scnt = 0;
  int unsigned dly = 5;
  bit          stub_en = 1'b1;
  int          n_cs = 0;
  always @(posedge clk) begin
    if (core_start) scnt <= 1;
    else if (scnt != 0) scnt <= scnt + 1;
    if (core_start) n_cs <= n_cs + 1;
    s_done <= s_core_start;
  end
  assign core_done = stub_en && (scnt == dly);

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_main(input logic [127:0] k, n, a, d, t, input bit thr, input bit poke);
    int b = 0;
    int guard = 0;
    bit v;
    while (b < 16 && guard < 400) begin
      @(negedge clk);
      guard++;
      v = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      key_in = k[127-b*8 -: 8];
      nonce_in = n[127-b*8 -: 8];
      ad_in = a[127-b*8 -: 8];
      data_in = d[127-b*8 -: 8];
      tag_in = t[127-b*8 -: 8];
      start = poke && (b == 0 || b == 7);
      if (v && in_ready) b++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    check("load_beats", 128'(b), 128'd16);
  endtask

  task automatic run_main(input bit m, input logic [127:0] k, n, a, d);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    check("core_start", core_start, 1'b1);
    check("core_mode", core_mode, m);
    check("core_key", core_key, k);
    check("core_nonce", core_nonce, n);
    check("core_ad", core_ad, a);
    check("core_data", core_data, d);
    @(negedge clk);
    check("core_start_pulse", core_start, 1'b0);
  endtask

  task automatic unload_main(input bit thr, input int nb, output logic [127:0] rd, output logic [127:0] rt);
    int j = 0;
    int guard = 0;
    bit r;
    rd = '0;
    rt = '0;
    while (j < nb && guard < 2000) begin
      @(negedge clk);
      guard++;
      r = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        rd = {rd[119:0], data_out};
        rt = {rt[119:0], tag_out};
        j++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("unload_beats", 128'(j), 128'(nb));
    if (nb == 16) check("out_valid_idle", out_valid, 1'b0);
  endtask

  logic [127:0] rd, rt, kv, nv, tv;
  logic [63:0]  av;
  logic [31:0]  dv, sd;
  logic [3:0]   zacc;
  int           cs0, guard;

  initial begin
    rst = 1'b0;
    {in_valid, mode, start, out_ready} = '0;
    {key_in, nonce_in, ad_in, data_in, tag_in} = '0;
    {s_in_valid, s_start, s_out_ready} = '0;
    {s_key, s_nonce, s_ad, s_data, s_tag} = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_tag_out", tag_out, 8'h00);
    check("rst_auth_fail", auth_fail, 1'b0);
    check("rst_lat_cnt", lat_cnt, 16'h0000);
    check("rst_core_start", core_start, 1'b0);
    check("rst_s_in_ready", s_in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // encrypt, start poked in IDLE and LOAD, tag_in junk
    cs0 = n_cs;
    load_main(KEY, KEY, '0, '0, ~TAG, 1'b0, 1'b1);
    check("start_ignored", 128'(n_cs - cs0), 128'd0);
    check("armed_in_ready", in_ready, 1'b0);
    run_main(1'b0, KEY, KEY, '0, '0);
    unload_main(1'b0, 16, rd, rt);
    check("enc_result", rd, RES);
    check("enc_tag", rt, TAG);
    check("enc_auth", auth_fail, 1'b0);
    check("enc_lat", lat_cnt, 16'd5);
    check("enc_one_start", 128'(n_cs - cs0), 128'd1);

    // decrypt, matching tag, 37-cycle core
    dly = 37;
    load_main(KEY, NON2, AD2, DAT2, TAG, 1'b0, 1'b0);
    run_main(1'b1, KEY, NON2, AD2, DAT2);
    unload_main(1'b0, 16, rd, rt);
    check("dec_ok_result", rd, RES);
    check("dec_ok_auth", auth_fail, 1'b0);
    check("dec_ok_lat", lat_cnt, 16'd37);

    // decrypt, tag differs in bit 0
    load_main(KEY, NON2, AD2, DAT2, TAG ^ 128'd1, 1'b0, 1'b0);
    run_main(1'b1, KEY, NON2, AD2, DAT2);
    unload_main(1'b0, 16, rd, rt);
    check("dec_bad_result", rd, 128'd0);
    check("dec_bad_tag", rt, TAG);
    check("dec_bad_auth", auth_fail, 1'b1);

    // throttled encrypt must match the unthrottled one
    dly = 5;
    load_main(KEY, KEY, '0, '0, ~TAG, 1'b1, 1'b0);
    run_main(1'b0, KEY, KEY, '0, '0);
    unload_main(1'b1, 16, rd, rt);
    check("thr_result", rd, RES);
    check("thr_tag", rt, TAG);
    check("thr_auth", auth_fail, 1'b0);
    check("thr_lat", lat_cnt, 16'd5);

    // reset during unload beat 5, then a clean run
    load_main(KEY, NON2, AD2, DAT2, TAG, 1'b0, 1'b0);
    run_main(1'b0, KEY, NON2, AD2, DAT2);
    unload_main(1'b0, 5, rd, rt);
    check("mid_out_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_lat", lat_cnt, 16'd0);
    check("abort_data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rerun_in_ready", in_ready, 1'b1);
    load_main(KEY, KEY, '0, '0, ~TAG, 1'b0, 1'b0);
    run_main(1'b0, KEY, KEY, '0, '0);
    unload_main(1'b0, 16, rd, rt);
    check("rerun_result", rd, RES);
    check("rerun_tag", rt, TAG);

    // narrow instance: AD beyond beat 15 and data beyond beat 7 carry junk
    kv = KEY; nv = NON2; av = AD_S; dv = DAT_S; tv = TAG;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_key = kv[127-4*b -: 4];
      s_nonce = nv[127-4*b -: 4];
      s_tag = tv[127-4*b -: 4];
      s_ad = (b < 16) ? av[63-4*b -: 4] : 4'hF;
      s_data = (b < 8) ? dv[31-4*b -: 4] : 4'hF;
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    check("s_armed_in_ready", s_in_ready, 1'b0);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("s_core_start", s_core_start, 1'b1);
    check("s_core_key", s_core_key, KEY);
    check("s_core_nonce", s_core_nonce, NON2);
    check("s_core_ad", s_core_ad, AD_S);
    check("s_core_data", s_core_data, DAT_S);
    sd = '0; rt = '0; zacc = '0;
    s_out_ready = 1'b1;
    begin
      int j = 0;
      guard = 0;
      while (j < 32 && guard < 200) begin
        @(negedge clk);
        guard++;
        if (s_out_valid) begin
          if (j < 8) sd = {sd[27:0], s_data_out};
          else zacc = zacc | s_data_out;
          rt = {rt[123:0], s_tag_out};
          j++;
        end
      end
      check("s_unload_beats", 128'(j), 128'd32);
    end
    s_out_ready = 1'b0;
    check("s_result", sd, RES_S);
    check("s_data_zero_tail", zacc, 4'h0);
    check("s_tag", rt, TAG);
    check("s_lat", s_lat_cnt, 16'd1);

    // core never finishes: latency saturates
    stub_en = 1'b0;
    load_main(KEY, KEY, '0, '0, '0, 1'b0, 1'b0);
    run_main(1'b0, KEY, KEY, '0, '0);
    repeat (70000) @(negedge clk);
    check("hang_lat", lat_cnt, 16'hFFFF);
    check("hang_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1 check("hang_rst_lat", lat_cnt, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_serial_io.md
ASCON_SERIAL_IO -- requirements
Module: ascon_serial_io

Interface
REQ-001 Parameter K, default 128, key length in bits.
REQ-002 Parameter L, default 128, associated-data length in bits.
REQ-003 Parameter Y, default 128, plaintext/ciphertext length in bits.
REQ-004 Parameter W, default 8, bits transferred per beat; K, L, Y and 128 SHALL each be multiples of W (elaboration error otherwise).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_valid / in_ready  in / out  1 / 1  load-beat handshake.
REQ-008 key_in, nonce_in, ad_in, data_in, tag_in  in  W each  one slice of each lane per beat; tag_in is the expected tag, used in decrypt only.
REQ-009 mode  in  1  0 = encrypt, 1 = decrypt; sampled at start acceptance.
REQ-010 start  in  1  request to run the core.
REQ-011 core_start  out  1; core_mode  out  1; core_key  out  K; core_nonce  out  128; core_ad  out  L; core_data  out  Y  (parallel operands to the AEAD core).
REQ-012 core_done  in  1; core_result  in  Y; core_tag  in  128  (core completion and results).
REQ-013 out_valid / out_ready  out / in  1 / 1  unload-beat handshake.
REQ-014 data_out, tag_out  out  W each; auth_fail  out  1; lat_cnt  out  16  (core cycles of the last run).

Function
REQ-015 The block SHALL use FSM states IDLE, LOAD, ARMED, RUN, UNLOAD, with M = max(K,L,Y,128).
REQ-016 IDLE: in_ready=1; the first accepted beat SHALL move the FSM to LOAD with beat counter=1; if M/W=1, the first beat SHALL move it directly to ARMED.
REQ-017 A beat is accepted iff in_valid && in_ready; beat i (0-based) SHALL supply lane bits [len-1-i*W -: W], MSB first, only while i < len/W; slices beyond a lane's length SHALL be ignored.
REQ-018 LOAD SHALL advance to ARMED on acceptance of beat M/W-1; in_ready SHALL be 0 in ARMED, RUN and UNLOAD.
REQ-019 start SHALL be ignored in IDLE and LOAD; in ARMED, start=1 SHALL latch mode, pulse core_start for exactly one cycle, clear lat_cnt and enter RUN.
REQ-020 core_* operand outputs SHALL be held stable from ARMED through the end of RUN.
REQ-021 RUN: lat_cnt SHALL increment each cycle core_done=0 and saturate at 16'hFFFF; on core_done=1 the block SHALL capture core_result and core_tag and enter UNLOAD on the next cycle.
REQ-022 Decrypt: at capture, auth_fail SHALL be set to (core_tag != loaded tag_in value); if set, captured result SHALL be replaced by all zeros.
REQ-023 Encrypt: auth_fail SHALL be 0; tag_in contents SHALL be ignored.
REQ-024 UNLOAD: out_valid=1; beat j SHALL present result bits [Y-1-j*W -: W] (zero once j ≥ Y/W) and tag bits [127-j*W -: W] (zero once j ≥ 128/W); data SHALL be held stable while out_ready=0.
REQ-025 Transfer of beat max(Y,128)/W-1 SHALL return the FSM to IDLE with out_valid=0; auth_fail and lat_cnt SHALL hold until the next start.
REQ-026 core_done outside RUN SHALL be ignored; start and in_valid during UNLOAD SHALL be ignored.

Reset
REQ-027 On rst=0, asynchronously: FSM=IDLE, counters=0, all lane registers=0, core_start=0, out_valid=0, data_out=0, tag_out=0, auth_fail=0, lat_cnt=0, in_ready=0 while rst=0.
REQ-028 Reset mid-load, mid-run or mid-unload SHALL abort the operation with no residual state; in_ready SHALL be 1 on the first clock after rst deasserts.

Verification
REQ-029 Default params, 16 beats key=000102..0F, nonce=000102..0F, ad=00, data=00, then start, mode=0 -> one core_start pulse, operands match loaded values, 16 unload beats reproduce a stubbed core_result/core_tag MSB-first, auth_fail=0.
REQ-030 Decrypt, tag_in equal to stub core_tag -> auth_fail=0, data_out reproduces core_result; tag_in differing in bit 0 -> auth_fail=1, all data_out beats 8'h00.
REQ-031 Stub core_done after 37 cycles -> lat_cnt=37; core_done never asserted for 70000 cycles -> lat_cnt=16'hFFFF.
REQ-032 Random in_valid/out_ready throttling (50%) -> identical results to the no-stall run; start in IDLE/LOAD ignored (no core_start).
REQ-033 K=128, L=64, Y=32, W=4 -> 32 load beats, AD lane ignored after beat 15, data_out zero after beat 7, tag beats 0-31 correct.
REQ-034 rst asserted during UNLOAD beat 5 -> out_valid=0 immediately, in_ready=1 on the first clock after release, a subsequent full run correct.
